// File: rtl/coreir_pipe_pkg.sv
// Shared types for the coreir pipeline register: per-stage operation encoding
// (reset handled in-stage ahead of these) and the occupancy counter width helper.
package coreir_pipe_pkg;

   // Priority inside a stage: flush beats load, load beats drain, else hold.
   typedef enum logic [1:0] {
      OP_HOLD  = 2'd0,
      OP_LOAD  = 2'd1,
      OP_DRAIN = 2'd2,
      OP_FLUSH = 2'd3
   } stage_op_e;

   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic stage_op_e stage_op(input logic clr, input logic load, input logic adv);
      if (clr)       return OP_FLUSH;
      else if (load) return OP_LOAD;
      else if (adv)  return OP_DRAIN;
      else           return OP_HOLD;
   endfunction

endpackage

// File: rtl/coreir_pipe_stage.sv
// One data+valid pipeline stage: synchronous reset, then flush/load/drain/hold.
// Data only changes on reset, flush or a load of a valid word.
module coreir_pipe_stage
   import coreir_pipe_pkg::*;
#(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             clk,
   input  logic             i_rst,
   input  stage_op_e        i_op,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q,
   output logic             o_v
);

   logic [WIDTH-1:0] r_q;
   logic             r_v;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_q <= INIT;
         r_v <= 1'b0;
      end else begin
         case (i_op)
            OP_FLUSH: begin
               r_q <= INIT;
               r_v <= 1'b0;
            end
            OP_LOAD: begin
               r_q <= i_d;
               r_v <= 1'b1;
            end
            OP_DRAIN: r_v <= 1'b0;
            default:  ;
         endcase
      end
   end

   assign o_q = r_q;
   assign o_v = r_v;

endmodule

// File: rtl/coreir_pipe_reg.sv
// DEPTH-stage valid/ready pipeline register with bubble collapse; latency DEPTH, 1 word/cycle.
// in_ready is combinational from out_ready; optional occupancy output under COREIR_PIPE_COUNT_EN.
module coreir_pipe_reg
   import coreir_pipe_pkg::*;
#(
   parameter int               WIDTH = 16,
   parameter int               DEPTH = 2,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] D,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Q
`ifdef COREIR_PIPE_COUNT_EN
   ,
   output logic [count_width(DEPTH)-1:0] count
`endif
);

   if (DEPTH < 1) begin : g_bad_depth
      $error("coreir_pipe_reg: DEPTH must be at least 1");
   end

   logic [WIDTH-1:0] w_q [DEPTH];
   logic [DEPTH-1:0] w_v;
   logic [DEPTH-1:0] w_adv;
   logic             w_in_xfer;

   // A valid stage moves unless every stage above it is full and the output is stalled.
   always_comb begin : p_advance
      logic w_full_above;
      w_full_above = 1'b1;
      w_adv        = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         w_adv[k]     = w_v[k] & (out_ready | ~w_full_above);
         w_full_above = w_full_above & w_v[k];
      end
   end

   assign in_ready  = ~rst & ~clr & (~w_v[0] | w_adv[0]);
   assign w_in_xfer = in_valid & in_ready;

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic             w_ld;
      logic [WIDTH-1:0] w_d;
      stage_op_e        w_op;

      if (k == 0) begin : g_head
         assign w_ld = w_in_xfer;
         assign w_d  = D;
      end else begin : g_body
         assign w_ld = w_adv[k-1];
         assign w_d  = w_q[k-1];
      end

      assign w_op = stage_op(clr, w_ld, w_adv[k]);

      coreir_pipe_stage #(
         .WIDTH (WIDTH),
         .INIT  (INIT)
      ) u_stage (
         .clk   (clk),
         .i_rst (rst),
         .i_op  (w_op),
         .i_d   (w_d),
         .o_q   (w_q[k]),
         .o_v   (w_v[k])
      );
   end

   assign out_valid = w_v[DEPTH-1];
   assign Q         = w_q[DEPTH-1];

`ifdef COREIR_PIPE_COUNT_EN
   localparam int            CW    = count_width(DEPTH);
   localparam logic [CW-1:0] C_ONE = CW'(1);

   logic [CW-1:0] r_count;
   logic          w_out_xfer;

   assign w_out_xfer = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_count <= '0;
      end else begin
         case ({w_in_xfer, w_out_xfer})
            2'b10:   r_count <= r_count + C_ONE;
            2'b01:   r_count <= r_count - C_ONE;
            default: ;
         endcase
      end
   end

   assign count = r_count;
`endif

endmodule

// File: doc/coreir_pipe_reg.md
COREIR_PIPE_REG -- requirements
Module: coreir_pipe_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width in bits, legal range 1 or more.
REQ-002 SHALL have parameter DEPTH, default 2: number of register stages, legal range 1 or more; DEPTH=0 is illegal and SHALL fail elaboration.
REQ-003 SHALL have parameter INIT, default 0: WIDTH-bit value loaded into every stage's data on reset and on clear.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its posedge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port clr, input, 1 bit: synchronous flush request.
REQ-007 SHALL have port in_valid, input, 1 bit: the upstream offers D.
REQ-008 SHALL have port in_ready, output, 1 bit: stage 0 can accept this cycle.
REQ-009 SHALL have port D, input, WIDTH bits: input data.
REQ-010 SHALL have port out_valid, output, 1 bit: the last stage holds a valid word.
REQ-011 SHALL have port out_ready, input, 1 bit: the downstream accepts Q.
REQ-012 SHALL have port Q, output, WIDTH bits: last-stage data.

Function
REQ-013 SHALL hold DEPTH stages; each stage has a WIDTH-bit data register and a 1-bit valid flag.
REQ-014 A transfer SHALL occur when valid and ready are both 1 on the same posedge, on the input side and on the output side independently.
REQ-015 Stage k (k < DEPTH-1) SHALL advance into stage k+1 when stage k+1 is empty or stage k+1 is itself advancing (bubble collapse).
REQ-016 The last stage SHALL empty when out_ready=1 and it does not receive new data.
REQ-017 in_ready SHALL equal (stage 0 empty) OR (stage 0 advancing); it is combinational from out_ready through the chain, and no other combinational input-to-output path SHALL exist.
REQ-018 Latency with no stall SHALL be DEPTH cycles from input acceptance to out_valid=1; sustained throughput SHALL be 1 word per cycle.
REQ-019 Q SHALL be last-stage data; out_valid SHALL be the last-stage valid flag.
REQ-020 Data order SHALL be preserved; no word is dropped or duplicated under any in_valid/out_ready pattern.
REQ-021 A stage's data SHALL hold when its valid is 0 or it is stalled; only valid words overwrite data.
REQ-022 Full pipeline (all DEPTH valid) with out_ready=0: in_ready=0, all stages hold.
REQ-023 Full pipeline with out_ready=1: simultaneous output and input transfer SHALL occur in the same cycle, and occupancy SHALL be unchanged.
REQ-024 Empty pipeline: out_valid=0, in_ready=1, and Q retains its last value.
REQ-025 clr=1 SHALL, at the posedge, clear all valid flags and load INIT into all data; any input or output handshake in that cycle SHALL be discarded (in_ready forced to 0, out_valid unaffected combinationally).

Reset
REQ-026 rst=1 at a posedge SHALL clear all valid flags and load INIT into all data; rst takes priority over clr and over handshakes.
REQ-027 While rst=1, in_ready SHALL be 0; after reset, out_valid=0, Q=INIT and in_ready=1.
REQ-028 Reset asserted mid-stream SHALL discard all words in flight with no partial output.

Configuration
REQ-029 With macro COREIR_PIPE_COUNT_EN defined, the block SHALL add output count, width $clog2(DEPTH+1), equal to the number of valid stages, registered, and reset and cleared to 0.
REQ-030 Without COREIR_PIPE_COUNT_EN, the count port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Package coreir_pipe_pkg SHALL hold the count-width function (clog2 of DEPTH+1) and the shared reset/clear priority encoding constants.
REQ-032 One sub-module, coreir_pipe_stage (WIDTH, INIT), SHALL implement one data+valid stage with load/hold/flush; the top SHALL instantiate DEPTH copies via generate and compute the advance chain.

Verification (WIDTH=8, DEPTH=3, INIT=8'hA5)
REQ-033 Reset: rst=1 for 2 cycles -> out_valid=0, Q=8'hA5, in_ready=1 on the first cycle after rst=0; count=0 if enabled.
REQ-034 Streaming: out_ready=1, send 8'h01..8'h06 back-to-back -> Q=8'h01 with out_valid=1 exactly 3 cycles after the first acceptance, then one word per cycle in order.
REQ-035 Backpressure: out_ready=0, offer 8'h10..8'h14 -> exactly 3 words accepted, then in_ready=0; raise out_ready -> 8'h10,11,12 emerge, and in_ready=1 in the same cycle as the first output.
REQ-036 Bubble collapse: send 8'h20, idle 1 cycle, send 8'h21 with out_ready=0 -> both words end in adjacent stages; occupancy=2 and in_ready=1.
REQ-037 Clear mid-stream: 2 words in flight, clr=1 with in_valid=1 and D=8'h33 -> next cycle out_valid=0, Q=8'hA5, and 8'h33 never appears at Q.
REQ-038 Priority: rst=1 and clr=1 together while full -> reset behaviour of REQ-026; random in_valid/out_ready for 10k cycles -> scoreboard shows in-order delivery with no loss or duplication.
